dmem_cache: RTL and testbench
=============================

Name: dmem_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage (memRead/memWrite, ALUOutM, writeDataM, readDataM) and a slower handshake-based data memory.
- Read hits return data combinationally with no stall.
- Read misses and all writes hold the pipeline via `stall` until the backing memory completes the access.

Parameters:
- INDEX_BITS, 6, cache index width; the cache holds 2^INDEX_BITS one-word lines.
- DATA_WIDTH, 32, word width; fixed at 32 for this core.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- memRead  input  1  load request from memory stage
- memWrite  input  1  store request from memory stage
- addr  input  32  byte address (ALUOutM); addr[1:0] ignored
- writeData  input  32  store data (writeDataM)
- readData  output  32  load data to memory stage (readDataM)
- stall  output  1  freeze pipeline, combinational
- memReq  output  1  backing-memory request
- memWe  output  1  backing-memory write enable
- memAddr  output  32  word-aligned address, {addr[31:2],2'b00}
- memWData  output  32  backing-memory write data
- memRData  input  32  backing-memory read data
- memReady  input  1  backing-memory completion, one-cycle pulse
- hitCount  output  32  read-hit counter (optional feature)
- missCount  output  32  read-miss counter (optional feature)

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[31:INDEX_BITS+2]
  - Storage per line: valid bit, tag, data word.
- hit = valid[index] & (tagArr[index]==tag).
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - memRead & hit: readData = dataArr[index] the same cycle; stall=0; stay IDLE.
  - memRead & miss: stall=1; next state FILL.
  - memWrite: stall=1; next state WRITE. memWrite takes priority if both are asserted.
  - No request: stall=0, readData=0.
- FILL:
  - memReq=1, memWe=0, memAddr from addr; stall=1 until memReady.
  - On the memReady cycle: stall=0, readData=memRData (bypass); line gets valid=1, tag, and data at the clock edge; next state IDLE.
- WRITE:
  - memReq=1, memWe=1, memWData=writeData; stall=1 until memReady.
  - On the memReady cycle: stall=0. If the line hits, dataArr[index] is updated at the edge. If it misses, the line is untouched (no allocate). Next state IDLE.
- The pipeline holds addr/writeData/memRead/memWrite stable while stall=1; the block relies on this and does not latch the request.
- memReq, memWe, memAddr, and memWData are stable from request until memReady. memReady outside FILL/WRITE is ignored.
- Latency:
  - Read hit: 0 extra cycles.
  - Read miss or write: 1 + N cycles stalled, where N is cycles from memReq to memReady; minimum total 2 cycles with stall high for the first.
- Reset: state=IDLE, all valid bits=0, memReq=0, memWe=0, stall=0, readData=0, counters=0.
- Reset during FILL/WRITE: the access is abandoned, memReq drops after the reset edge, and no line is written. A late memReady is ignored.
- Back-to-back requests: the request following a completed miss is evaluated in IDLE on the next cycle and sees the filled line.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - hitCount increments on each IDLE read-hit cycle.
  - missCount increments on each IDLE-to-FILL transition.
  - Both counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: both ports are tied to 0 and no counter logic is built; the port list is unchanged.

Test Plan:
- Reset, then memRead addr=0x00000040, memory returns 0xDEADBEEF after 3 cycles:
  - stall=1 for 3 cycles, readData=0xDEADBEEF on the memReady cycle.
  - Repeating the read gives the same data with stall=0 and no memReq.
- After the fill, memWrite addr=0x40 data=0x12345678, memReady after 2 cycles:
  - memReq=1 and memWe=1 with memWData=0x12345678, stall released on memReady.
  - Next read of 0x40 hits with 0x12345678.
- memWrite to uncached addr=0x80 data=0x1:
  - Write-through completes.
  - Read of 0x80 misses (memReq asserted), confirming no allocate.
- Conflict with INDEX_BITS=6:
  - Fill 0x00000040, then read 0x00000140 (same index, different tag): miss, fill replaces the line.
  - Read 0x40 misses again.
- Assert rst while in FILL before memReady:
  - memReq=0 next cycle; a later memReady pulse is ignored.
  - Read of the same address misses; all valid bits are cleared.
- With DCACHE_STATS_EN, perform 1 miss then 3 hits: hitCount=3, missCount=1. Without the macro, both read 0.

Source files
------------

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a handshake data memory.
// Optional read hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dmem_cache #(
  parameter int INDEX_BITS = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  stall,
  output logic                  memReq,
  output logic                  memWe,
  output logic [31:0]           memAddr,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData,
  input  logic                  memReady,
  output logic [31:0]           hitCount,
  output logic [31:0]           missCount
);
  // Handshake: memReq/memWe/memAddr/memWData are held from the request until the
  // single-cycle memReady pulse that completes it; memReady with no request is ignored.
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                  state_q;
  logic                    memReq_q, memWe_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_BITS-1:0]     tag_q  [LINES];
  logic [DATA_WIDTH-1:0]   data_q [LINES];

  logic [INDEX_BITS-1:0]   index;
  logic [TAG_BITS-1:0]     tag;
  logic                    hit;
  logic                    unused_addr_bits;

  assign index            = addr[INDEX_BITS+1:2];
  assign tag              = addr[31:INDEX_BITS+2];
  assign hit              = valid_q[index] && (tag_q[index] == tag);
  assign unused_addr_bits = ^addr[1:0];

  assign memReq   = memReq_q;
  assign memWe    = memWe_q;
  assign memAddr  = {addr[31:2], 2'b00};
  assign memWData = writeData;

  always_comb begin
    stall    = 1'b0;
    readData = '0;
    case (state_q)
      IDLE: begin
        if (memWrite)     stall = 1'b1;
        else if (memRead) begin
          if (hit) readData = data_q[index];
          else     stall    = 1'b1;
        end
      end
      FILL: begin
        stall = !memReady;
        if (memReady) readData = memRData;
      end
      WRITE:   stall = !memReady;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      memReq_q <= 1'b0;
      memWe_q  <= 1'b0;
      valid_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memWrite) begin
            state_q  <= WRITE;
            memReq_q <= 1'b1;
            memWe_q  <= 1'b1;
          end else if (memRead && !hit) begin
            state_q  <= FILL;
            memReq_q <= 1'b1;
            memWe_q  <= 1'b0;
          end
        end
        FILL: begin
          if (memReady) begin
            state_q        <= IDLE;
            memReq_q       <= 1'b0;
            valid_q[index] <= 1'b1;
          end
        end
        WRITE: begin
          if (memReady) begin
            state_q  <= IDLE;
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data storage needs no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (!rst && memReady) begin
      if (state_q == FILL) begin
        tag_q[index]  <= tag;
        data_q[index] <= memRData;
      end else if (state_q == WRITE && hit) begin
        data_q[index] <= writeData;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        idle_rd;

  assign idle_rd = (state_q == IDLE) && memRead && !memWrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_rd && hit && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (idle_rd && !hit && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`else
  assign hitCount  = 32'd0;
  assign missCount = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache: table of cache accesses with hand-computed results,
// plus hand sequences for reset mid-fill and the statistics counters.
module tb_dmem_cache;
  logic        clk, rst;
  logic        memRead, memWrite;
  logic [31:0] addr, writeData, readData;
  logic        stall, memReq, memWe;
  logic [31:0] memAddr, memWData, memRData;
  logic        memReady;
  logic [31:0] hitCount, missCount;

  int checks   = 0;
  int failures = 0;

  dmem_cache #(.INDEX_BITS(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .writeData(writeData), .readData(readData), .stall(stall),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memReady(memReady),
    .hitCount(hitCount), .missCount(missCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;        // memReady on this memReq cycle (1 = first)
    logic [31:0] mdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_stall;
    logic        exp_req;
  } vec_t;

  vec_t vecs[12];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the access completes.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input logic [31:0] md,
                        output logic [31:0] got_rd, output int stall_cyc,
                        output logic req_seen, output logic bus_ok, output logic timed_out);
    int  req_cnt;
    bit  done;
    req_cnt = 0; done = 0; stall_cyc = 0; req_seen = 0; bus_ok = 1; got_rd = 'x;
    memRead = rd; memWrite = wr; addr = a; writeData = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (memReq === 1'b1) begin
        req_seen = 1;
        req_cnt++;
        if (memWe !== wr || memAddr !== {a[31:2], 2'b00} || (wr && memWData !== wd))
          bus_ok = 0;
      end
      memReady = (memReq === 1'b1) && (req_cnt == lat);
      memRData = memReady ? md : 32'hBAD0_BAD0;
      #2;
      if (stall === 1'b0) begin
        done   = 1;
        got_rd = readData;
      end else stall_cyc++;
    end
    timed_out = !done;
    @(posedge clk); #1;
    memReady = 0; memRead = 0; memWrite = 0;
  endtask

  logic [31:0] got_rd;
  int          stall_cyc;
  logic        req_seen, bus_ok, timed_out;

  initial begin
    // rd wr addr wdata lat mdata chk exp_rd stall req
    vecs[0]  = '{1, 0, 32'h40,  0,            3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 3, 1};
    vecs[1]  = '{1, 0, 32'h40,  0,            1, 32'hBAD0BAD0, 1, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{0, 1, 32'h40,  32'h12345678, 2, 32'h0,        0, 32'h0,        2, 1};
    vecs[3]  = '{1, 0, 32'h40,  0,            1, 32'hBAD0BAD0, 1, 32'h12345678, 0, 0};
    vecs[4]  = '{0, 1, 32'h80,  32'h00000001, 1, 32'h0,        0, 32'h0,        1, 1};
    vecs[5]  = '{1, 0, 32'h80,  0,            1, 32'h00000001, 1, 32'h00000001, 1, 1};
    vecs[6]  = '{1, 0, 32'h140, 0,            2, 32'hCAFEF00D, 1, 32'hCAFEF00D, 2, 1};
    vecs[7]  = '{1, 0, 32'h140, 0,            1, 32'hBAD0BAD0, 1, 32'hCAFEF00D, 0, 0};
    vecs[8]  = '{1, 0, 32'h43,  0,            1, 32'h12345678, 1, 32'h12345678, 1, 1};
    vecs[9]  = '{1, 0, 32'h80,  0,            1, 32'hBAD0BAD0, 1, 32'h00000001, 0, 0};
    vecs[10] = '{1, 1, 32'h80,  32'h000055AA, 1, 32'h0,        0, 32'h0,        1, 1};
    vecs[11] = '{1, 0, 32'h82,  0,            1, 32'hBAD0BAD0, 1, 32'h000055AA, 0, 0};

    rst = 1; memRead = 0; memWrite = 0; addr = 0; writeData = 0;
    memRData = 0; memReady = 0;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    #2;
    check32("reset_stall",     {31'b0, stall},  32'd0);
    check32("reset_memReq",    {31'b0, memReq}, 32'd0);
    check32("reset_memWe",     {31'b0, memWe},  32'd0);
    check32("reset_readData",  readData,        32'd0);
    check32("reset_hitCount",  hitCount,        32'd0);
    check32("reset_missCount", missCount,       32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].lat, vecs[i].mdata,
             got_rd, stall_cyc, req_seen, bus_ok, timed_out);
      check32($sformatf("v%0d_timeout", i), {31'b0, timed_out}, 32'd0);
      check32($sformatf("v%0d_stall_cycles", i), stall_cyc, vecs[i].exp_stall);
      check32($sformatf("v%0d_memReq_seen", i), {31'b0, req_seen}, {31'b0, vecs[i].exp_req});
      check32($sformatf("v%0d_bus", i), {31'b0, bus_ok}, 32'd1);
      if (vecs[i].chk_rd)
        check32($sformatf("v%0d_readData", i), got_rd, vecs[i].exp_rd);
    end

    // Reset in the middle of a fill of 0x200, then a stray memReady.
    memRead = 1; addr = 32'h200;
    #2; check32("rf_stall_idle", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    check32("rf_memReq_fill", {31'b0, memReq}, 32'd1);
    rst = 1;
    @(posedge clk); #1;
    check32("rf_memReq_after_rst", {31'b0, memReq}, 32'd0);
    rst = 0; memRead = 0;
    memReady = 1; memRData = 32'hFFFF0000;
    #2; check32("rf_stray_ready_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    memReady = 0;
    check32("rf_memReq_stray", {31'b0, memReq}, 32'd0);

    // Valid bits cleared: 0x40 misses again; then 3 hits for the counters.
    access(1, 0, 32'h40, 0, 1, 32'h12345678, got_rd, stall_cyc, req_seen, bus_ok, timed_out);
    check32("post_rst_miss_req", {31'b0, req_seen}, 32'd1);
    check32("post_rst_miss_data", got_rd, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      access(1, 0, 32'h40, 0, 1, 32'hBAD0BAD0, got_rd, stall_cyc, req_seen, bus_ok, timed_out);
      check32($sformatf("stats_hit%0d_req", k), {31'b0, req_seen}, 32'd0);
      check32($sformatf("stats_hit%0d_data", k), got_rd, 32'h12345678);
    end
`ifdef DCACHE_STATS_EN
    check32("hitCount", hitCount, 32'd3);
    check32("missCount", missCount, 32'd1);
`else
    check32("hitCount", hitCount, 32'd0);
    check32("missCount", missCount, 32'd0);
`endif

    // The abandoned fill of 0x200 must not have left a line behind.
    access(1, 0, 32'h200, 0, 2, 32'h0BADF00D, got_rd, stall_cyc, req_seen, bus_ok, timed_out);
    check32("abandoned_line_req", {31'b0, req_seen}, 32'd1);
    check32("abandoned_line_data", got_rd, 32'h0BADF00D);
    check32("abandoned_line_stall", stall_cyc, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
